// File: rtl/out_pkt_fifo.sv
// out_pkt_fifo: packet-aware OUT FIFO between the SIE and the application.
// Bytes are written speculatively, committed on EOP, rolled back on error/NAK.
module out_pkt_fifo #(
  parameter int OUT_MAXPACKETSIZE = 64,
  parameter int DEPTH             = 128,
  parameter int DATA_W            = 8,
  parameter int NAK_MODE          = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clk_gate_i,
  input  logic [7:0]                    out_data_i,
  input  logic                          out_valid_i,
  input  logic                          out_err_i,
  input  logic                          out_ready_i,
  output logic                          out_nak_o,
  output logic                          out_full_o,
  output logic                          out_empty_o,
  output logic [$clog2(DEPTH+2)-1:0]    out_level_o,
  output logic [7:0]                    app_out_data_o,
  output logic                          app_out_last_o,
  output logic                          app_out_valid_o,
  input  logic                          app_out_ready_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(DEPTH + 2);
  localparam logic [CW-1:0] DEP_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C = CW'(OUT_MAXPACKETSIZE);

  if (DATA_W != 8) begin : g_bad_width
    $error("out_pkt_fifo: DATA_W must be 8");
  end

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, cm_ptr, sp_ptr;
  logic [CW-1:0] cm_cnt, sp_cnt, un_cnt;
  logic [CW-1:0] cm_nxt, sp_nxt;
  logic          in_pkt, nak_q, full_q;
  logic [7:0]    dout_q;
  logic          last_q, vld_q;
  logic          ev, err_ev, eop_ev, dat_ev;
  logic          rollback, commit, nak_now;
  logic          wr, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
  endfunction

  // Event decode, NAK decision and next counts (pop and SIE event net out)
  always_comb begin
    un_cnt   = sp_cnt - cm_cnt;
    ev       = clk_gate_i & out_ready_i;
    err_ev   = ev & out_err_i;
    eop_ev   = ev & ~out_err_i & ~out_valid_i;
    dat_ev   = ev & ~out_err_i & out_valid_i;
    nak_now  = nak_q | (sp_cnt == DEP_C)
             | ((NAK_MODE == 1) & ~in_pkt
                & ((DEP_C - sp_cnt) < MAX_C));
    rollback = err_ev | (eop_ev & nak_q);
    commit   = eop_ev & ~nak_q & (un_cnt != '0);
    wr       = dat_ev & ~nak_now;
    pop      = (cm_cnt != '0) & (~vld_q | app_out_ready_i);
    cm_nxt   = cm_cnt - CW'(pop) + (commit ? un_cnt : '0);
    sp_nxt   = sp_cnt - CW'(pop) + CW'(wr)
             - (rollback ? un_cnt : '0);
  end

  // Pointers, counts and packet status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      cm_ptr <= '0;
      sp_ptr <= '0;
      cm_cnt <= '0;
      sp_cnt <= '0;
      in_pkt <= 1'b0;
      nak_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      cm_cnt <= cm_nxt;
      sp_cnt <= sp_nxt;
      full_q <= (sp_nxt == DEP_C);
      if (pop) rd_ptr <= inc(rd_ptr);
      if (wr) sp_ptr <= inc(sp_ptr);
      else if (rollback) sp_ptr <= cm_ptr;
      if (commit) cm_ptr <= sp_ptr;
      if (err_ev | eop_ev) begin
        in_pkt <= 1'b0;
        nak_q  <= 1'b0;
      end else if (dat_ev) begin
        if (nak_now) nak_q <= 1'b1;
        else in_pkt <= 1'b1;
      end
    end
  end

  // Storage: write data with last=0, tag final byte on commit
  always_ff @(posedge clk_i) begin
    if (wr) mem[sp_ptr] <= {1'b0, out_data_i};
    if (commit) mem[dec(sp_ptr)][8] <= 1'b1;
  end

  // Output register: refill from committed data, clear when drained
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
      last_q <= 1'b0;
    end else if (pop) begin
      vld_q            <= 1'b1;
      {last_q, dout_q} <= mem[rd_ptr];
    end else if (vld_q & app_out_ready_i) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
      last_q <= 1'b0;
    end
  end

  assign out_nak_o       = nak_q;
  assign out_full_o      = full_q;
  assign out_empty_o     = (cm_cnt == '0) & ~vld_q;
  assign out_level_o     = LW'(cm_cnt) + LW'(vld_q);
  assign app_out_data_o  = dout_q;
  assign app_out_last_o  = last_q;
  assign app_out_valid_o = vld_q;

endmodule
